// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg
//   Shared constants and op encodings for the top-of-stack controller.
//   WIDTH      data width of TOS and storage words
//   AW         storage address width (storage depth = 2**AW)
//   DEPTH      number of storage words
//   DEPTH_MAX  depth value reported when the stack is full (TOS + storage)
//   op_e       2-bit op code: OP_NOP, OP_PUSH, OP_REPLACE, OP_POP
package stack_ctrl_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] DEPTH_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_REPLACE = 2'b10,
        OP_POP     = 2'b11
    } op_e;

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl
//   Top-of-stack controller feeding an external 16-entry stack storage RAM.
//   The top item lives in a register; items below it live in storage at
//   storage[sp], storage[sp-1], ... The storage RAM (sync write, async read)
//   is instantiated beside this block and connected through the stk_* ports.
//
//   Build option STACK_CTRL_GUARD_EN:
//     defined   - push while full / pop while empty are suppressed (no sp, tos
//                 or depth change, no storage write); err still sets.
//     undefined - circular stack: such ops execute, sp wraps, overflow
//                 overwrites the oldest item and underflow returns stale
//                 storage data. depth saturates and err still sets.
//
//   Ports
//     clk       in   clock, rising edge
//     reset     in   asynchronous reset, active-high
//     op_valid  in   execute op_code this cycle
//     op_code   in   00 nop, 01 push, 10 replace, 11 pop
//     op_data   in   new TOS value for push/replace
//     tos       out  registered top of stack
//     nos       out  next-on-stack (storage read data, combinational)
//     stk_ra    out  storage read address (= sp)
//     stk_rd    in   storage read data, async read
//     stk_we    out  storage write enable
//     stk_wa    out  storage write address
//     stk_wd    out  storage write data
//     depth     out  items held incl. TOS, 0..16
//     full      out  depth == 16
//     empty     out  depth == 0
//     err       out  sticky overflow/underflow flag
//     err_clr   in   synchronous clear of err
module stack_ctrl
    import stack_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [AW-1:0]    stk_ra,
    input  logic [WIDTH-1:0] stk_rd,
    output logic             stk_we,
    output logic [AW-1:0]    stk_wa,
    output logic [WIDTH-1:0] stk_wd,
    output logic [AW:0]      depth,
    output logic             full,
    output logic             empty,
    output logic             err,
    input  logic             err_clr
);

    logic [AW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [AW:0]      depth_q, depth_d;
    logic             err_q, err_d;

    op_e  op;
    logic is_push, is_pop, is_rep;
    logic full_w, empty_w;
    logic overflow, underflow;
    logic exec_push, exec_pop;

    assign full_w  = (depth_q == DEPTH_MAX);
    assign empty_w = (depth_q == '0);

    always_comb begin
        op        = op_e'(op_code);
        is_push   = op_valid && (op == OP_PUSH);
        is_pop    = op_valid && (op == OP_POP);
        is_rep    = op_valid && (op == OP_REPLACE);
        overflow  = is_push && full_w;
        underflow = is_pop && empty_w;
`ifdef STACK_CTRL_GUARD_EN
        exec_push = is_push && !full_w;
        exec_pop  = is_pop && !empty_w;
`else
        exec_push = is_push;
        exec_pop  = is_pop;
`endif
    end

    always_comb begin
        sp_d    = sp_q;
        tos_d   = tos_q;
        depth_d = depth_q;

        if (exec_push) begin
            // The old TOS moves into storage at sp+1 through stk_wd this cycle.
            sp_d  = sp_q + 1'b1;
            tos_d = op_data;
            if (!full_w) begin
                depth_d = depth_q + 1'b1;
            end
        end else if (exec_pop) begin
            // nos is storage[sp], already on stk_rd before the edge.
            sp_d  = sp_q - 1'b1;
            tos_d = stk_rd;
            if (!empty_w) begin
                depth_d = depth_q - 1'b1;
            end
        end else if (is_rep) begin
            tos_d = op_data;
        end

        // A new error in the same cycle as err_clr keeps the flag set.
        if (overflow || underflow) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            tos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Keep the storage write off while reset is held so an op caught by reset
    // cannot leave a partial write behind.
    assign stk_we = exec_push && !reset;
    assign stk_wa = sp_q + 1'b1;
    assign stk_wd = tos_q;
    assign stk_ra = sp_q;
    assign nos    = stk_rd;

    assign tos    = tos_q;
    assign depth  = depth_q;
    assign full   = full_w;
    assign empty  = empty_w;
    assign err    = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

`ifdef STACK_CTRL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] tos, nos, stk_rd, stk_wd;
    logic [AW-1:0]    stk_ra, stk_wa;
    logic             stk_we;
    logic [AW:0]      depth;
    logic             full, empty, err, err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    stack_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_data(op_data), .tos(tos), .nos(nos), .stk_ra(stk_ra),
        .stk_rd(stk_rd), .stk_we(stk_we), .stk_wa(stk_wa), .stk_wd(stk_wd),
        .depth(depth), .full(full), .empty(empty), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Storage RAM: synchronous write, asynchronous read.
    logic [WIDTH-1:0] ram [0:DEPTH-1];
    always @(posedge clk) if (stk_we) ram[stk_wa] <= stk_wd;
    assign stk_rd = ram[stk_ra];

    // Reference model of the stack and its storage.
    logic [WIDTH-1:0] m_mem [0:DEPTH-1];
    logic [AW-1:0]    m_sp;
    logic [WIDTH-1:0] m_tos;
    logic [AW:0]      m_depth;
    logic             m_err;

    typedef struct {
        logic [WIDTH-1:0] tos;
        logic [AW:0]      depth;
        logic [AW-1:0]    sp;
        logic             err;
        logic             we;
    } exp_t;
    exp_t exp_q[$];

    logic             s_we;
    logic [AW-1:0]    s_wa;
    logic [WIDTH-1:0] s_wd;

    task automatic model_reset();
        m_sp = '0; m_tos = '0; m_depth = '0; m_err = 1'b0;
    endtask

    task automatic model_op(input logic v, input logic [1:0] c, input logic [WIDTH-1:0] d, input logic clr);
        logic push, pop, rep, mfull, mempty, ovf, unf, xpush, xpop;
        logic [AW-1:0] wa;
        exp_t e;
        push   = v && (c == 2'b01);
        pop    = v && (c == 2'b11);
        rep    = v && (c == 2'b10);
        mfull  = (m_depth == 5'd16);
        mempty = (m_depth == 5'd0);
        ovf    = push && mfull;
        unf    = pop && mempty;
        xpush  = push && !(GUARD && mfull);
        xpop   = pop && !(GUARD && mempty);
        e.we   = xpush;
        if (xpush) begin
            wa = m_sp + 4'd1;
            m_mem[wa] = m_tos;
            m_sp = wa;
            m_tos = d;
            if (!mfull) m_depth = m_depth + 5'd1;
        end else if (xpop) begin
            m_tos = m_mem[m_sp];
            m_sp = m_sp - 4'd1;
            if (!mempty) m_depth = m_depth - 5'd1;
        end else if (rep) begin
            m_tos = d;
        end
        if (ovf || unf) m_err = 1'b1;
        else if (clr)   m_err = 1'b0;
        e.tos = m_tos; e.depth = m_depth; e.sp = m_sp; e.err = m_err;
        exp_q.push_back(e);
    endtask

    // Drives one op starting just after a rising edge; returns 1 ns after the next edge.
    task automatic step(input logic v, input logic [1:0] c, input logic [WIDTH-1:0] d, input logic clr);
        op_valid = v; op_code = c; op_data = d; err_clr = clr;
        model_op(v, c, d, clr);
        #2;
        s_we = stk_we; s_wa = stk_wa; s_wd = stk_wd;
        @(posedge clk); #1;
        op_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        op_valid = 1'b0; err_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        op_valid = 1'b0; op_code = 2'b00; op_data = '0; err_clr = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_tests++; if (tos !== 16'h0)  begin n_fail++; $display("FAIL reset_tos: got %h want 0000", tos); end
        n_tests++; if (depth !== 5'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
        n_tests++; if (err !== 1'b0 || stk_we !== 1'b0 || stk_ra !== 4'd0) begin n_fail++; $display("FAIL reset_misc: err=%b we=%b sp=%0d want 0/0/0", err, stk_we, stk_ra); end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] dat [3] = '{16'h1111, 16'h2222, 16'h3333};
        exp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, 2'b01, dat[i], 1'b0);
            else       step(1'b1, 2'b11, 16'h0, 1'b0);
            if (i == 2) begin
                n_tests++; if (s_wa !== 4'd3 || s_wd !== 16'h2222) begin n_fail++; $display("FAIL push_write: wa=%0d wd=%h want 3/2222", s_wa, s_wd); end
                n_tests++; if (tos !== 16'h3333 || nos !== 16'h2222 || depth !== 5'd3) begin n_fail++; $display("FAIL push3: tos=%h nos=%h depth=%0d want 3333/2222/3", tos, nos, depth); end
            end
            if (i == 4) begin
                n_tests++; if (tos !== 16'h1111) begin n_fail++; $display("FAIL pop2_tos: got %h want 1111", tos); end
            end
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL push_pop: scoreboard empty at step %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL push_pop step%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (depth !== 5'd0 || empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL pop_end: depth=%0d empty=%b err=%b want 0/1/0", depth, empty, err); end
    endtask

    task automatic test_replace();
        logic [1:0]       cod [3] = '{2'b01, 2'b01, 2'b10};
        logic [WIDTH-1:0] dat [3] = '{16'h1111, 16'h2222, 16'hBEEF};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, cod[i], dat[i], 1'b0);
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL replace: scoreboard empty at step %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL replace step%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (tos !== 16'hBEEF || nos !== 16'h1111 || depth !== 5'd2) begin n_fail++; $display("FAIL replace_state: tos=%h nos=%h depth=%0d want BEEF/1111/2", tos, nos, depth); end
        n_tests++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL replace_we: got %b want 0", s_we); end
    endtask

    task automatic test_full();
        exp_t e;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 2'b01, (i == 17) ? 16'hAAAA : 16'(i), 1'b0);
            if (i == 16) begin
                n_tests++; if (full !== 1'b1 || depth !== 5'd16 || tos !== 16'h0010 || err !== 1'b0) begin n_fail++; $display("FAIL full16: full=%b depth=%0d tos=%h err=%b want 1/16/0010/0", full, depth, tos, err); end
            end
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL full: scoreboard empty at push %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL full push%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (err !== 1'b1 || depth !== 5'd16) begin n_fail++; $display("FAIL overflow_err: err=%b depth=%0d want 1/16", err, depth); end
        if (GUARD) begin
            n_tests++; if (tos !== 16'h0010 || stk_ra !== 4'd0 || s_we !== 1'b0) begin n_fail++; $display("FAIL overflow_guard: tos=%h sp=%0d we=%b want 0010/0/0", tos, stk_ra, s_we); end
        end else begin
            n_tests++; if (tos !== 16'hAAAA || stk_ra !== 4'd1 || s_we !== 1'b1) begin n_fail++; $display("FAIL overflow_wrap: tos=%h sp=%0d we=%b want AAAA/1/1", tos, stk_ra, s_we); end
        end
    endtask

    task automatic test_underflow();
        logic [1:0] cod [3] = '{2'b11, 2'b00, 2'b11};
        logic       clr [3] = '{1'b0, 1'b1, 1'b1};
        logic       want_err [3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, cod[i], 16'h0, clr[i]);
            n_tests++; if (err !== want_err[i]) begin n_fail++; $display("FAIL underflow_err step%0d: got %b want %b", i, err, want_err[i]); end
            if (i == 0 && GUARD) begin
                n_tests++; if (tos !== 16'h0 || depth !== 5'd0 || stk_ra !== 4'd0) begin n_fail++; $display("FAIL underflow_guard: tos=%h depth=%0d sp=%0d want 0000/0/0", tos, depth, stk_ra); end
            end
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL underflow: scoreboard empty at step %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL underflow step%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (depth !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL underflow_depth: depth=%0d empty=%b want 0/1", depth, empty); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      step(1'b1, 2'b11, 16'h0, 1'b0);
            else if (i < 6)  step(1'b1, 2'b01, 16'h0050 + 16'(i), 1'b0);
            else begin
                // Reset lands in the middle of a push at depth 5.
                n_tests++; if (depth !== 5'd5 || err !== 1'b1) begin n_fail++; $display("FAIL pre_reset: depth=%0d err=%b want 5/1", depth, err); end
                op_valid = 1'b1; op_code = 2'b01; op_data = 16'h9999;
                #2 reset = 1'b1;
                model_reset();
                #1;
                n_tests++; if (tos !== 16'h0 || depth !== 5'd0 || empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL mid_reset: tos=%h depth=%0d empty=%b err=%b want 0000/0/1/0", tos, depth, empty, err); end
                n_tests++; if (stk_we !== 1'b0 || stk_ra !== 4'd0) begin n_fail++; $display("FAIL mid_reset_port: we=%b sp=%0d want 0/0", stk_we, stk_ra); end
                op_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                step(1'b1, 2'b01, 16'h0077, 1'b0);
            end
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL reset_mid: scoreboard empty at step %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL reset_mid step%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (tos !== 16'h0077 || depth !== 5'd1) begin n_fail++; $display("FAIL after_reset_push: tos=%h depth=%0d want 0077/1", tos, depth); end
    endtask

    task automatic test_idle();
        exp_t e;
        step(1'b1, 2'b01, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, 2'b01, 16'h5555, 1'b0);
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL idle: scoreboard empty at step %0d", i); end
            else begin
                e = exp_q.pop_front(); n_tests++;
                if (tos !== e.tos || depth !== e.depth || stk_ra !== e.sp || err !== e.err || s_we !== e.we) begin
                    n_fail++;
                    $display("FAIL idle step%0d: tos=%h depth=%0d sp=%0d err=%b we=%b want tos=%h depth=%0d sp=%0d err=%b we=%b",
                             i, tos, depth, stk_ra, err, s_we, e.tos, e.depth, e.sp, e.err, e.we);
                end
            end
        end
        n_tests++; if (tos !== 16'h1234 || depth !== 5'd2 || s_we !== 1'b0) begin n_fail++; $display("FAIL idle_hold: tos=%h depth=%0d we=%b want 1234/2/0", tos, depth, s_we); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        test_reset();
        test_push_pop();
        test_replace();
        test_full();
        test_underflow();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
